soc_clk_ctrl: RTL and testbench
===============================

// Module: soc_clk_ctrl
// PURPOSE
//   Parametrised clock-enable and run-control block for the SoC top.
//   - Runs off the single fast board clock and produces NUM_CH periodic one-cycle enable strobes.
//   - Produces one core-enable (core_ce) that the MIPS core, serial and screen logic qualify their registers with.
//   - Core mode is picked by two switches: run fast, run slow, single-step on a debounced button, or halt.
//   - Replaces fixed-divider clock generation; no derived clocks leave this block.
// PARAMETERS
//   NUM_CH    3                               number of periodic enable channels
//   DIV_W     32                              divider/counter width
//   DIV_LIST  {32'd90000,32'd450,32'd45}      packed divisors; channel i = DIV_LIST[i*DIV_W +: DIV_W]
//   FAST_DIV  450                             core_ce period in RUN_FAST (cycles)
//   SLOW_DIV  90000000                        core_ce period in RUN_SLOW (cycles)
//   DEB_CYC   4500000                         cycles step_btn must be stable to be accepted
// PORTS
//   clk       in   1            board clock, all logic on rising edge
//   rstn      in   1            asynchronous active-low reset
//   mode_sw   in   2            raw switches: 00 RUN_FAST, 01 RUN_SLOW, 10 STEP, 11 HALT
//   step_btn  in   1            raw single-step push button, active high
//   ce        out  NUM_CH       periodic one-cycle enables
//   core_ce   out  1            core enable strobe
//   mode      out  2            synchronised mode in effect
//   ce_count  out  32           number of core_ce pulses since reset
// BEHAVIOUR
//   Reset (async, rstn=0)
//     - all counters = 0; ce = 0, core_ce = 0, mode = 2'b11 (HALT), ce_count = 0.
//     - Synchronisers and debounce stable state = 0.
//     - Reset mid-operation aborts any partial count or debounce; no strobe in the cycle after release.
//   Channels
//     - Counter i runs 0..D-1 and wraps to 0, where D = divisor of channel i.
//     - ce[i] is registered: high for exactly one cycle, in the cycle after the counter reaches D-1.
//     - First pulse is D cycles after reset release. D <= 1: ce[i] high every cycle from the 1st cycle after reset.
//   Input synchronisation
//     - mode_sw and step_btn each pass through 2 flops; mode = synchronised mode_sw (2-cycle latency).
//     - On any change of mode, the core divider counter clears to 0.
//   Core divider
//     - RUN_FAST: core_ce pulses every FAST_DIV cycles, same rule as the channels.
//     - RUN_SLOW: core_ce pulses every SLOW_DIV cycles, same rule as the channels.
//     - STEP / HALT: the core divider is held at 0.
//   Debounce
//     - Counter increments while the synced button != stable state; clears to 0 when they are equal.
//     - When the count reaches DEB_CYC-1 with the input still different, stable toggles and the counter clears.
//     - A glitch shorter than DEB_CYC cycles never changes the stable state.
//   STEP mode
//     - Each 0->1 transition of the stable state gives exactly one core_ce pulse, in the next cycle.
//     - The release edge (1->0) gives no pulse.
//     - Presses accepted in any other mode are discarded; no pulse is queued for a later STEP entry.
//     - Entering STEP while the button is held gives no pulse until it is released and pressed again.
//   HALT: core_ce = 0 permanently. Channels keep running in every mode.
//   ce_count: +1 on every core_ce cycle; 32-bit, wraps FFFFFFFF -> 0.
//   Simultaneous events
//     - If a mode change and a divider terminal count land in the same cycle, the new mode wins.
//     - In that case no core_ce is emitted and the counter clears.
// TESTING (sim with DIV_LIST={8,3,1}, FAST_DIV=4, SLOW_DIV=10, DEB_CYC=4)
//   1 Reset release, mode_sw=00 -> ce[0] every cycle; ce[1] every 3rd cycle; ce[2] every 8th cycle.
//     Also core_ce every 4th cycle; ce_count=5 after the 5th pulse.
//   2 Switch 00->01 mid-count -> core_ce stops; first slow pulse 10 cycles after mode updates, then every 10.
//   3 mode_sw=10, step_btn 3-cycle glitch -> no core_ce.
//     Then a clean 20-cycle press -> exactly one core_ce, ce_count +1; release gives nothing.
//   4 Press held while in 11, then switch to 10 -> no core_ce.
//     Then release and re-press -> exactly one core_ce.
//   5 rstn low mid-step-debounce and mid-divide -> all outputs 0, mode=11 immediately, without waiting for clk.
//     After release, counts restart from 0.
//   6 Force ce_count to 32'hFFFFFFFF, then one core_ce -> ce_count=0.

Source files
------------

// File: rtl/soc_clk_ctrl.sv
// Clock-enable and run-control for the SoC: periodic channel strobes plus a core enable
// whose cadence is chosen by synchronised mode switches and a debounced step button.
module soc_clk_ctrl #(
    parameter int unsigned                    NUM_CH   = 3,
    parameter int unsigned                    DIV_W    = 32,
    parameter logic [NUM_CH*DIV_W-1:0]        DIV_LIST = {32'd90000, 32'd450, 32'd45},
    parameter logic [DIV_W-1:0]               FAST_DIV = 450,
    parameter logic [DIV_W-1:0]               SLOW_DIV = 90000000,
    parameter logic [DIV_W-1:0]               DEB_CYC  = 4500000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        mode_sw,
    input  logic              step_btn,
    output logic [NUM_CH-1:0] ce,
    output logic              core_ce,
    output logic [1:0]        mode,
    output logic [31:0]       ce_count
);

    typedef enum logic [1:0] {
        RUN_FAST = 2'b00,
        RUN_SLOW = 2'b01,
        STEP     = 2'b10,
        HALT     = 2'b11
    } mode_e;

    // Terminal count index; divisors of 0 or 1 collapse to "fire every cycle".
    function automatic logic [DIV_W-1:0] last_idx(input logic [DIV_W-1:0] d);
        return (d > 1) ? d - DIV_W'(1) : '0;
    endfunction

    localparam logic [DIV_W-1:0] FAST_LAST = last_idx(FAST_DIV);
    localparam logic [DIV_W-1:0] SLOW_LAST = last_idx(SLOW_DIV);
    localparam logic [DIV_W-1:0] DEB_LAST  = last_idx(DEB_CYC);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [DIV_W-1:0] LAST = last_idx(DIV_LIST[gi*DIV_W +: DIV_W]);
        logic [DIV_W-1:0] cnt;
        logic             ce_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt  <= '0;
                ce_q <= 1'b0;
            end else if (cnt >= LAST) begin
                cnt  <= '0;
                ce_q <= 1'b1;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                ce_q <= 1'b0;
            end
        end

        assign ce[gi] = ce_q;
    end

    logic [1:0]       mode_sw_p0;
    logic             btn_p0, btn_p1;
    logic             stable, stable_p1;
    logic [DIV_W-1:0] deb_cnt;
    logic [DIV_W-1:0] core_cnt;
    logic             mode_chg, core_tc, step_fire, core_fire, running;

    assign mode_chg  = (mode_sw_p0 != mode);
    assign running   = (mode == RUN_FAST) || (mode == RUN_SLOW);
    assign step_fire = (mode == STEP) && stable && !stable_p1;
    // A pending mode change suppresses any strobe due in the same cycle.
    assign core_fire = !mode_chg && (core_tc || step_fire);

    always_comb begin
        core_tc = 1'b0;
        case (mode)
            RUN_FAST: core_tc = (core_cnt >= FAST_LAST);
            RUN_SLOW: core_tc = (core_cnt >= SLOW_LAST);
            default:  core_tc = 1'b0;
        endcase
    end

    // Stage p0 -> p1: two-flop synchronisers; mode is the second stage of mode_sw.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_sw_p0 <= 2'b00;
            mode       <= HALT;
            btn_p0     <= 1'b0;
            btn_p1     <= 1'b0;
        end else begin
            mode_sw_p0 <= mode_sw;
            mode       <= mode_sw_p0;
            btn_p0     <= step_btn;
            btn_p1     <= btn_p0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_cnt   <= '0;
            stable    <= 1'b0;
            stable_p1 <= 1'b0;
        end else begin
            stable_p1 <= stable;
            if (btn_p1 == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt >= DEB_LAST) begin
                deb_cnt <= '0;
                stable  <= ~stable;
            end else begin
                deb_cnt <= deb_cnt + DIV_W'(1);
            end
        end
    end

    // ce_count is written only on a strobe so it holds its value otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_cnt <= '0;
            core_ce  <= 1'b0;
            ce_count <= '0;
        end else begin
            core_ce <= core_fire;
            if (core_fire)
                ce_count <= ce_count + 32'd1;
            if (mode_chg || core_tc || !running)
                core_cnt <= '0;
            else
                core_cnt <= core_cnt + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_soc_clk_ctrl.sv
// Directed bench for soc_clk_ctrl with small divisors; k counts clock edges since reset release.
module tb_soc_clk_ctrl;

    logic        clk;
    logic        rstn;
    logic [1:0]  mode_sw;
    logic        step_btn;
    logic [2:0]  ce;
    logic        core_ce;
    logic [1:0]  mode;
    logic [31:0] ce_count;

    int tests;
    int fails;
    int k;

    soc_clk_ctrl #(
        .NUM_CH   (3),
        .DIV_W    (32),
        .DIV_LIST ({32'd8, 32'd3, 32'd1}),
        .FAST_DIV (32'd4),
        .SLOW_DIV (32'd10),
        .DEB_CYC  (32'd4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mode_sw  (mode_sw),
        .step_btn (step_btn),
        .ce       (ce),
        .core_ce  (core_ce),
        .mode     (mode),
        .ce_count (ce_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // ch0 D=1 every cycle, ch1 D=3 at k=3,6,..., ch2 D=8 at k=8,16,...
    task automatic chk_ch();
        logic [2:0] e;
        e = {(k % 8 == 0), (k % 3 == 0), 1'b1};
        chk("channels", 32'(ce), 32'(e));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        k        = 0;
        rstn     = 1'b0;
        mode_sw  = 2'b00;
        step_btn = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_core_ce", 32'(core_ce), 32'd0);
        chk("rst_mode", 32'(mode), 32'd3);
        chk("rst_count", ce_count, 32'd0);

        // Test 1: RUN_FAST from reset; core_ce at k=5,9,13,...
        rstn = 1'b1;
        k    = 0;
        for (int i = 0; i < 23; i++) begin
            tick();
            chk_ch();
            chk("t1_core_ce", 32'(core_ce), 32'(k >= 5 && (k - 5) % 4 == 0));
            if (k == 2) chk("t1_mode", 32'(mode), 32'd0);
            if (k == 21) chk("t1_count5", ce_count, 32'd5);
        end

        // Test 2: switch to RUN_SLOW at k=23; mode updates at k=25, colliding with a fast tc
        mode_sw = 2'b01;
        for (int i = 0; i < 23; i++) begin
            tick();
            chk_ch();
            chk("t2_core_ce", 32'(core_ce), 32'(k == 35 || k == 45));
            if (k == 24) chk("t2_mode_lat", 32'(mode), 32'd0);
            if (k == 25) chk("t2_mode_new", 32'(mode), 32'd1);
        end
        chk("t2_count7", ce_count, 32'd7);

        // Test 3: STEP mode, 3-cycle glitch then a clean 20-cycle press
        mode_sw = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ch();
            chk("t3_enter_core_ce", 32'(core_ce), 32'd0);
        end
        chk("t3_mode", 32'(mode), 32'd2);
        step_btn = 1'b1;
        repeat (3) tick();
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_glitch_core_ce", 32'(core_ce), 32'd0);
        end
        chk("t3_glitch_count", ce_count, 32'd7);
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_press_core_ce", 32'(core_ce), 32'(k == 70));
        end
        step_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_ch();
            chk("t3_release_core_ce", 32'(core_ce), 32'd0);
        end
        chk("t3_count8", ce_count, 32'd8);

        // Test 4: press held in HALT, enter STEP, then release and re-press
        mode_sw = 2'b11;
        repeat (4) tick();
        step_btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t4_halt_core_ce", 32'(core_ce), 32'd0);
        end
        mode_sw = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_held_core_ce", 32'(core_ce), 32'd0);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_rel_core_ce", 32'(core_ce), 32'd0);
        end
        step_btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t4_repress_core_ce", 32'(core_ce), 32'(k == 149));
        end
        step_btn = 1'b0;
        repeat (10) tick();
        chk("t4_count9", ce_count, 32'd9);
        chk("t4_mode", 32'(mode), 32'd2);

        // Test 5: asynchronous reset mid-divide and mid-debounce
        mode_sw = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_ch();
        end
        step_btn = 1'b1;
        repeat (2) tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_async_ce", 32'(ce), 32'd0);
        chk("t5_async_core_ce", 32'(core_ce), 32'd0);
        chk("t5_async_mode", 32'(mode), 32'd3);
        chk("t5_async_count", ce_count, 32'd0);
        step_btn = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_held_ce", 32'(ce), 32'd0);
        rstn = 1'b1;
        k    = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_ch();
            chk("t5_restart_core_ce", 32'(core_ce), 32'(k == 5 || k == 9));
        end
        chk("t5_count2", ce_count, 32'd2);

        // Test 6: ce_count wrap; next fast strobe is due at k=13
        force dut.ce_count = 32'hFFFF_FFFF;
        tick();
        release dut.ce_count;
        chk("t6_preset", ce_count, 32'hFFFF_FFFF);
        tick();
        chk("t6_hold", ce_count, 32'hFFFF_FFFF);
        tick();
        chk("t6_core_ce", 32'(core_ce), 32'd1);
        chk("t6_wrap", ce_count, 32'd0);
        tick();
        chk("t6_after", ce_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
